// File: rtl/fa_bist_ctrl_if.sv
// Handshake bundle between the full-adder BIST controller and the adder under test.
interface fa_bist_ctrl_if #(
  parameter int unsigned ERR_W = 4
);
  logic             start;
  logic             dut_sum;
  logic             dut_c_out;
  logic             a;
  logic             b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             first_err_valid;
  logic [2:0]       first_err_vec;

  // Controller side: drives the vector and the result flags.
  modport master (
    input  start,
    input  dut_sum,
    input  dut_c_out,
    output a,
    output b,
    output c_in,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_err_valid,
    output first_err_vec
  );

  // Requester / adder side: issues start and returns the adder response.
  modport slave (
    output start,
    output dut_sum,
    output dut_c_out,
    input  a,
    input  b,
    input  c_in,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_err_valid,
    input  first_err_vec
  );
endinterface

// File: rtl/fa_bist_ctrl.sv
// Self-test controller for a 1-bit full adder: walks vectors 0..7, checks each response
// against a golden model and reports pass/fail, a saturating error count and the first
// failing vector.
module fa_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic          clk,
  input  logic          rst,
  fa_bist_ctrl_if.master bus
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fvalid_q, fvalid_d;
  logic [2:0]       fvec_q, fvec_d;

  logic exp_sum, exp_c_out, mismatch;

  // Golden full-adder response for the vector currently driven.
  always_comb begin
    exp_sum   = ^vec_q;
    exp_c_out = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
    mismatch  = (bus.dut_sum != exp_sum) || (bus.dut_c_out != exp_c_out);
  end

  // Next-state and result update; the adder response is captured on the edge that ends CHECK.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fvalid_d = fvalid_q;
    fvec_d   = fvec_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d  = StSettle;
          vec_d    = 3'd0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = '0;
          fvalid_d = 1'b0;
          fvec_d   = 3'd0;
        end
      end
      StSettle: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + 1'b1;
          end
          if (!fvalid_q) begin
            fvalid_d = 1'b1;
            fvec_d   = vec_q;
          end
        end
        if (vec_q == 3'd7) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          vec_d   = vec_q + 3'd1;
          state_d = StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      vec_q    <= 3'd0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fvalid_q <= 1'b0;
      fvec_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    bus.a               = vec_q[2];
    bus.b               = vec_q[1];
    bus.c_in            = vec_q[0];
    bus.busy            = busy_q;
    bus.done            = done_q;
    bus.pass            = pass_q;
    bus.err_count       = err_q;
    bus.first_err_valid = fvalid_q;
    bus.first_err_vec   = fvec_q;
  end

endmodule
